// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the multicycle controller: FSM states,
// opcode values, ALU operation codes and the decoded instruction class.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_AND   = 4'h3;
  localparam logic [3:0] OP_OR    = 4'h4;
  localparam logic [3:0] OP_NOT   = 4'h5;
  localparam logic [3:0] OP_LI    = 4'h6;
  localparam logic [3:0] OP_LT    = 4'h7;
  localparam logic [3:0] OP_LOAD  = 4'h8;
  localparam logic [3:0] OP_STORE = 4'h9;
  localparam logic [3:0] OP_JUMP  = 4'hA;
  localparam logic [3:0] OP_BZ    = 4'hB;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [3:0] ALU_PASS = 4'h0;
  localparam logic [3:0] ALU_ADD  = 4'h1;
  localparam logic [3:0] ALU_SUB  = 4'h2;

  typedef enum logic [3:0] {
    CLS_NOP,
    CLS_ALU,
    CLS_LI,
    CLS_LOAD,
    CLS_STORE,
    CLS_JUMP,
    CLS_BRANCH,
    CLS_HALT,
    CLS_ILLEGAL
  } op_class_e;

endpackage

// File: rtl/multicycle_control_if.sv
// Memory handshake between the multicycle controller (master) and memory (slave).
interface multicycle_control_if;
  logic mem_read;
  logic mem_write;
  logic i_or_d;
  logic mem_ready;

  modport master (output mem_read, output mem_write, output i_or_d, input mem_ready);
  modport slave  (input mem_read, input mem_write, input i_or_d, output mem_ready);
endinterface

// File: rtl/ctrl_decode.sv
// Combinational opcode classifier. Opcode 1011 (BZ) is legal only when
// CTRL_BRANCH_EN is defined; otherwise it classifies as illegal.
module ctrl_decode
  import cpu_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 4
) (
  input  logic [OPCODE_W-1:0] op,
  output op_class_e           cls
);

  logic [3:0] nib;

  always_comb begin
    nib = op[3:0];
    cls = CLS_ILLEGAL;
    // Any set bit above the low nibble makes the opcode illegal.
    if ((op >> 4) == '0) begin
      case (nib)
        OP_NOP:                                           cls = CLS_NOP;
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT, OP_LT:     cls = CLS_ALU;
        OP_LI:                                            cls = CLS_LI;
        OP_LOAD:                                          cls = CLS_LOAD;
        OP_STORE:                                         cls = CLS_STORE;
        OP_JUMP:                                          cls = CLS_JUMP;
`ifdef CTRL_BRANCH_EN
        OP_BZ:                                            cls = CLS_BRANCH;
`endif
        OP_HALT:                                          cls = CLS_HALT;
        default:                                          cls = CLS_ILLEGAL;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM (RST/FETCH/DECODE/EXEC/MEM/WB/HALT).
// Define CTRL_BRANCH_EN to enable the BZ (1011) conditional branch.
module multicycle_control
  import cpu_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int ALU_OP_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                alu_zero,
  multicycle_control_if.master mem,
  output logic                ir_write,
  output logic                pc_inc,
  output logic                pc_write,
  output logic                jump,
  output logic                reg_write,
  output logic                mem_to_reg,
  output logic                alu_src,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                halted,
  output logic                illegal,
  output logic [2:0]          state_o
);

  state_e              state_q, state_d;
  logic [OPCODE_W-1:0] op_q, op_d;
  logic [OPCODE_W-1:0] dec_op;
  op_class_e           cls;
  logic                mem_read, mem_write, i_or_d;

  // DECODE acts on the live opcode (op_q is only loaded at its end);
  // every later state works from the latched copy.
  assign dec_op = (state_q == ST_DECODE) ? opcode : op_q;

  ctrl_decode #(.OPCODE_W(OPCODE_W)) u_decode (
    .op  (dec_op),
    .cls (cls)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RST;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_inc     = 1'b0;
    pc_write   = 1'b0;
    jump       = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    alu_op     = '0;
    halted     = 1'b0;
    illegal    = 1'b0;

    case (state_q)
      ST_RST: state_d = ST_FETCH;

      ST_FETCH: begin
        mem_read = 1'b1;
        if (mem.mem_ready) begin
          ir_write = 1'b1;
          pc_inc   = 1'b1;
          state_d  = ST_DECODE;
        end
      end

      ST_DECODE: begin
        op_d = opcode;
        case (cls)
          CLS_ALU, CLS_LI, CLS_LOAD, CLS_STORE, CLS_BRANCH: state_d = ST_EXEC;
          CLS_JUMP: begin
            jump     = 1'b1;
            pc_write = 1'b1;
            state_d  = ST_FETCH;
          end
          CLS_HALT:    state_d = ST_HALT;
          CLS_ILLEGAL: begin
            illegal = 1'b1;
            state_d = ST_FETCH;
          end
          default:     state_d = ST_FETCH;
        endcase
      end

      ST_EXEC: begin
        case (cls)
          CLS_ALU: begin
            alu_op  = ALU_OP_W'(op_q[3:0]);
            state_d = ST_WB;
          end
          CLS_LI: begin
            alu_src = 1'b1;
            alu_op  = ALU_OP_W'(ALU_PASS);
            state_d = ST_WB;
          end
          CLS_LOAD, CLS_STORE: begin
            alu_src = 1'b1;
            alu_op  = ALU_OP_W'(ALU_ADD);
            state_d = ST_MEM;
          end
          CLS_BRANCH: begin
            alu_op = ALU_OP_W'(ALU_SUB);
            if (alu_zero) begin
              jump     = 1'b1;
              pc_write = 1'b1;
            end
            state_d = ST_FETCH;
          end
          default: state_d = ST_FETCH;
        endcase
      end

      ST_MEM: begin
        i_or_d = 1'b1;
        if (cls == CLS_STORE) mem_write = 1'b1;
        else                  mem_read  = 1'b1;
        if (mem.mem_ready) state_d = (cls == CLS_STORE) ? ST_FETCH : ST_WB;
      end

      ST_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (cls == CLS_LOAD);
        state_d    = ST_FETCH;
      end

      ST_HALT: halted = 1'b1;

      default: state_d = ST_RST;
    endcase
  end

  assign mem.mem_read  = mem_read;
  assign mem.mem_write = mem_write;
  assign mem.i_or_d    = i_or_d;
  assign state_o       = state_q;

endmodule
